// File: rtl/nibble_add_sched.sv
// Serial WIDTH-bit adder sequencer sharing one external 4-bit adder cell between two requesters.
// Optional signed-overflow output resp_ovf is enabled by defining NIBBLE_ADD_OVF_EN.
module nibble_add_sched #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_sum,
   output logic             resp_cout,
   output logic             resp_id,
`ifdef NIBBLE_ADD_OVF_EN
   output logic             resp_ovf,
`endif
   output logic             busy,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_sum,
   input  logic             add_cout
);

   localparam int NIB = WIDTH / 4;
   localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

   generate
      if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
         $error("nibble_add_sched: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [KW-1:0]    k;
   logic             carry;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             cin_reg;
   logic             last_grant;
   logic             grant_any;
   logic             winner;
   logic             handshake;
   logic             last_slice;

   // Round-robin arbitration: a lone requester wins, a tie goes to the one not granted last
   always_comb begin
      grant_any = 1'b0;
      winner    = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_any = 1'b1;
         winner    = ~last_grant;
      end else if (req0_valid) begin
         grant_any = 1'b1;
         winner    = 1'b0;
      end else if (req1_valid) begin
         grant_any = 1'b1;
         winner    = 1'b1;
      end else begin
         grant_any = 1'b0;
         winner    = 1'b0;
      end
   end

   // Ready decode and handshake/slice qualifiers
   always_comb begin
      handshake  = (state == IDLE) && grant_any;
      req0_ready = handshake && !winner;
      req1_ready = handshake && winner;
      last_slice = (k == KW'(NIB - 1));
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = handshake  ? RUN  : IDLE;
         RUN:     state_next = last_slice ? DONE : RUN;
         DONE:    state_next = resp_ready ? IDLE : DONE;
         default: state_next = IDLE;
      endcase
   end

   // State register; busy is registered alongside it so it tracks "state != IDLE" exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
      end
   end

   // Nibble mux toward the shared adder; slice 0 takes the requester's carry in
   always_comb begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
      if (state == RUN) begin
         for (int i = 0; i < NIB; i++) begin
            if (k == KW'(i)) begin
               add_a = a_reg[4*i +: 4];
               add_b = b_reg[4*i +: 4];
            end else begin
               add_a = add_a;
               add_b = add_b;
            end
         end
         add_cin = (k == '0) ? cin_reg : carry;
      end else begin
         add_a   = 4'h0;
         add_b   = 4'h0;
         add_cin = 1'b0;
      end
   end

   // Operand capture, per-slice sum accumulation and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         k          <= '0;
         carry      <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         cin_reg    <= 1'b0;
         last_grant <= 1'b1;
         resp_valid <= 1'b0;
         resp_sum   <= '0;
         resp_cout  <= 1'b0;
         resp_id    <= 1'b0;
`ifdef NIBBLE_ADD_OVF_EN
         resp_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (handshake) begin
                  a_reg      <= winner ? req1_a   : req0_a;
                  b_reg      <= winner ? req1_b   : req0_b;
                  cin_reg    <= winner ? req1_cin : req0_cin;
                  resp_id    <= winner;
                  last_grant <= winner;
                  k          <= '0;
                  carry      <= 1'b0;
               end
            end
            RUN: begin
               for (int i = 0; i < NIB; i++) begin
                  if (k == KW'(i)) begin
                     resp_sum[4*i +: 4] <= add_sum;
                  end
               end
               carry <= add_cout;
               if (last_slice) begin
                  k          <= '0;
                  resp_cout  <= add_cout;
                  resp_valid <= 1'b1;
`ifdef NIBBLE_ADD_OVF_EN
                  // add_sum[3] is the MSB of the final sum, landing this same edge
                  resp_ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                (add_sum[3] != a_reg[WIDTH-1]);
`endif
               end else begin
                  k <= k + KW'(1);
               end
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
               end
            end
            default: begin
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_add_sched.sv
// Self-checking bench for nibble_add_sched: an arithmetic reference model checked every cycle,
// plus directed scenarios with literal expectations. Define NIBBLE_ADD_OVF_EN to cover resp_ovf.
module tb_nibble_add_sched;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req0_valid = 1'b0, req1_valid = 1'b0;
   logic             req0_ready, req1_ready;
   logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic             req0_cin = 1'b0, req1_cin = 1'b0;
   logic             resp_valid, resp_cout, resp_id, busy;
   logic             resp_ready = 1'b1;
   logic [WIDTH-1:0] resp_sum;
   logic [3:0]       add_a, add_b, add_sum;
   logic             add_cin, add_cout;
`ifdef NIBBLE_ADD_OVF_EN
   logic             resp_ovf;
   logic             got_ovf;
`endif

   int checks   = 0;
   int failures = 0;

   // external shared 4-bit adder cell
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

   nibble_add_sched #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum), .resp_cout(resp_cout),
      .resp_id(resp_id),
`ifdef NIBBLE_ADD_OVF_EN
      .resp_ovf(resp_ovf),
`endif
      .busy(busy), .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: 0=idle 1=computing 2=response pending
   int      m_phase = 0;
   bit      m_last  = 1'b1;
   int      m_k     = 0;
   longint  m_a = 0, m_b = 0, m_cin = 0;
   bit      m_id = 1'b0;
   bit      grant_log[$];

   initial begin
      forever begin
         @(negedge clk);
         begin
            bit     exp_r0, exp_r1;
            longint total, mask, cin_k;
            exp_r0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
            exp_r1 = (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
            chk("req0_ready", req0_ready, exp_r0);
            chk("req1_ready", req1_ready, exp_r1);
            chk("resp_valid", resp_valid, m_phase == 2);
            chk("busy", busy, m_phase != 0);
            total = m_a + m_b + m_cin;
            if (m_phase == 1) begin
               mask  = (64'd1 << (4 * m_k)) - 64'd1;
               cin_k = (m_k == 0) ? m_cin : ((((m_a & mask) + (m_b & mask) + m_cin) >> (4 * m_k)) & 64'd1);
               chk("add_a", add_a, (m_a >> (4 * m_k)) & 64'hF);
               chk("add_b", add_b, (m_b >> (4 * m_k)) & 64'hF);
               chk("add_cin", add_cin, cin_k);
            end else begin
               chk("add_idle", {add_a, add_b, add_cin}, 9'd0);
            end
            if (m_phase == 2) begin
               chk("resp_sum", resp_sum, total & 64'hFFFF);
               chk("resp_cout", resp_cout, (total >> WIDTH) & 64'd1);
               chk("resp_id", resp_id, m_id);
`ifdef NIBBLE_ADD_OVF_EN
               chk("resp_ovf", resp_ovf, (m_a[WIDTH-1] == m_b[WIDTH-1]) && (total[WIDTH-1] != m_a[WIDTH-1]));
`endif
            end
            if (rst) begin
               m_phase = 0;
               m_last  = 1'b1;
            end else begin
               case (m_phase)
                  0: begin
                     if (exp_r0 || exp_r1) begin
                        m_id    = exp_r1;
                        m_a     = exp_r1 ? longint'(req1_a) : longint'(req0_a);
                        m_b     = exp_r1 ? longint'(req1_b) : longint'(req0_b);
                        m_cin   = exp_r1 ? longint'(req1_cin) : longint'(req0_cin);
                        m_last  = exp_r1;
                        m_k     = 0;
                        m_phase = 1;
                        grant_log.push_back(exp_r1);
                     end
                  end
                  1: begin
                     m_k++;
                     if (m_k == NIB) m_phase = 2;
                  end
                  default: if (resp_ready) m_phase = 0;
               endcase
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b, input bit cin);
      bit seen = 1'b0;
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         seen = id ? req1_ready : req0_ready;
      end
      if (!seen) chk("issue_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_resp(input bit id, input logic [15:0] sum, input bit cout);
      bit seen = 1'b0;
      resp_ready = 1'b1;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         seen = resp_valid;
      end
      if (!seen) chk("resp_timeout", 32'd0, 32'd1);
      chk("lit_sum", resp_sum, sum);
      chk("lit_cout", resp_cout, cout);
      chk("lit_id", resp_id, id);
`ifdef NIBBLE_ADD_OVF_EN
      got_ovf = resp_ovf;
`endif
      @(posedge clk); #1;
   endtask

   initial begin
      logic [3:0]       seq [4];
      logic [WIDTH-1:0] snap_sum;
      logic             snap_cout;
      int               base;
      bit               seen;
      seq = '{4'h4, 4'h3, 4'h2, 4'h1};

      // basic add with slice sequence
      do_reset();
      chk("reset_busy", busy, 1'b0);
      chk("reset_resp_valid", resp_valid, 1'b0);
      issue(1'b0, 16'h1234, 16'h1111, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("seq_add_a", add_a, seq[i]);
      end
      @(posedge clk); #1;
      wait_resp(1'b0, 16'h2345, 1'b0);

      // full carry chain
      issue(1'b1, 16'hFFFF, 16'h0001, 1'b0);
      wait_resp(1'b1, 16'h0000, 1'b1);
      issue(1'b1, 16'hFFFF, 16'h0000, 1'b1);
      wait_resp(1'b1, 16'h0000, 1'b1);

      // fairness: both valid from reset
      @(posedge clk); #1;
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = 16'h0101; req0_b = 16'h0202; req0_cin = 1'b0;
      req1_valid = 1'b1; req1_a = 16'h1000; req1_b = 16'hF000; req1_cin = 1'b1;
      base = grant_log.size();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         seen = (grant_log.size() >= base + 4);
      end
      if (!seen) chk("fair_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         seen = !busy;
      end
      if (!seen) chk("fair_idle_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
         chk("grant_order", (grant_log.size() > base + i) ? 32'(grant_log[base + i]) : 32'hEE, 32'(i % 2));

      // backpressure in DONE with a pending request
      resp_ready = 1'b0;
      issue(1'b0, 16'hA5A5, 16'h0F0F, 1'b1);
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         seen = resp_valid;
      end
      if (!seen) chk("bp_timeout", 32'd0, 32'd1);
      snap_sum = resp_sum; snap_cout = resp_cout;
      chk("bp_sum_lit", snap_sum, 16'hB4B5);
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_a = 16'h0F0F; req1_b = 16'h00F1; req1_cin = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_sum_stable", resp_sum, snap_sum);
         chk("bp_cout_stable", resp_cout, snap_cout);
         chk("bp_readys", {req0_ready, req1_ready}, 2'b00);
         chk("bp_busy", busy, 1'b1);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp_valid_at_take", resp_valid, 1'b1);
      @(negedge clk);
      chk("bp_idle_busy", busy, 1'b0);
      chk("bp_idle_valid", resp_valid, 1'b0);
      chk("bp_idle_ready1", req1_ready, 1'b1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_resp(1'b1, 16'h1000, 1'b0);

      // reset during slice 2 aborts the operation
      issue(1'b0, 16'h1234, 16'h4321, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_valid", resp_valid, 1'b0);
      @(posedge clk); #1;
      issue(1'b0, 16'h00FF, 16'h0001, 1'b0);
      wait_resp(1'b0, 16'h0100, 1'b0);

`ifdef NIBBLE_ADD_OVF_EN
      issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
      wait_resp(1'b0, 16'h8000, 1'b0);
      chk("ovf_7fff", got_ovf, 1'b1);
      issue(1'b1, 16'h8000, 16'h8000, 1'b0);
      wait_resp(1'b1, 16'h0000, 1'b1);
      chk("ovf_8000", got_ovf, 1'b1);
      issue(1'b0, 16'h0001, 16'hFFFF, 1'b0);
      wait_resp(1'b0, 16'h0000, 1'b1);
      chk("ovf_none", got_ovf, 1'b0);
`endif

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nibble_add_sched.md
Name: nibble_add_sched

Overview:
- Sequencer that shares one external 4-bit combinational ripple adder between two requesters.
- Performs WIDTH-bit additions serially, one nibble per cycle, LSB first, carrying between slices in a register.
- Sits between two client blocks, each with a valid/ready request channel, and the shared 4-bit adder cell. Returns results on one valid/ready response channel tagged with the requester id.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and >= 4, otherwise an elaboration-time error.
- NIB, WIDTH/4, number of nibble slices (derived, not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 accepted this cycle.
- req0_a  input  WIDTH  operand A.
- req0_b  input  WIDTH  operand B.
- req0_cin  input  1  carry in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0, for requester 1.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes result.
- resp_sum  output  WIDTH  result.
- resp_cout  output  1  final carry out.
- resp_id  output  1  requester that issued the operation.
- busy  output  1  high whenever state is not IDLE.
- add_a  output  4  nibble A to the shared adder.
- add_b  output  4  nibble B to the shared adder.
- add_cin  output  1  carry in to the shared adder.
- add_sum  input  4  adder sum, combinational in the same cycle.
- add_cout  input  1  adder carry out, same cycle.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - State IDLE; slice counter 0; carry register 0.
  - resp_valid, resp_sum, resp_cout, resp_id and busy all 0.
  - Round-robin pointer set so that requester 0 wins first.
- States: IDLE, RUN, DONE.
- IDLE:
  - Arbitration is combinational. If only one valid is high, that requester wins. If both are high, the requester not granted last wins.
  - reqN_ready = (state==IDLE) && winner==N. At most one ready is high in any cycle, and ready is never high outside IDLE.
  - On the handshake edge: latch a, b, cin and id; update the round-robin pointer; set counter k=0; go to RUN.
- RUN, slice k:
  - add_a = a_reg[4k+3:4k], add_b = b_reg[4k+3:4k].
  - add_cin = cin_reg when k==0, else carry_reg.
  - At the edge: sum_reg[4k+3:4k] <= add_sum; carry_reg <= add_cout; k <= k+1.
  - After slice NIB-1: resp_cout <= add_cout; go to DONE.
- DONE:
  - resp_valid=1. resp_sum, resp_cout and resp_id are held stable until resp_ready is sampled high.
  - Then resp_valid drops and the next state is IDLE.
- In IDLE and DONE, add_a, add_b and add_cin are driven 0.
- Latency: handshake at edge E0; slices are captured at edges E1..E_NIB; resp_valid is high from the cycle after E_NIB. With WIDTH=16, resp_valid is first sampled at E5.
- Peak throughput: one operation per NIB+2 cycles.
- Boundary conditions:
  - A valid dropped before ready: no operation, and no state change.
  - Requests arriving while busy: ready stays low and the requester must hold its request.
  - Both requesters always valid: grants strictly alternate.
  - Carry ripples across every slice, including all-ones operands with cin=1.
  - Wrap-around: the sum is modulo 2^WIDTH; resp_cout reports the carry out of the MSB.
  - rst during RUN or DONE: the operation is aborted, no response is issued, and the next cycle is in IDLE with reset values.
  - rst has priority over every handshake in the same cycle.

Optional Feature:
- Macro: NIBBLE_ADD_OVF_EN.
- When defined:
  - Adds output resp_ovf (1 bit), the signed two's-complement overflow: (a_reg[MSB]==b_reg[MSB]) && (resp_sum[MSB]!=a_reg[MSB]).
  - resp_ovf is registered on entry to DONE, reset to 0, and held with the response.
- When not defined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Basic add: rst high for 2 cycles; req0 a=0x1234, b=0x1111, cin=0 -> resp_sum=0x2345, resp_cout=0, resp_id=0; resp_valid first high at E5; add_a sequence 4,3,2,1.
- Full carry chain: req1 a=0xFFFF, b=0x0001, cin=0 -> sum 0x0000, cout 1, id 1. Then a=0xFFFF, b=0x0000, cin=1 -> sum 0x0000, cout 1.
- Fairness: both valid continuously from reset, 4 operations -> grant order 0,1,0,1; only one ready high per cycle.
- Backpressure: resp_ready held low for 3 cycles in DONE -> response stable, both readys 0, busy 1. On resp_ready=1 -> IDLE the next cycle.
- Reset mid-operation: assert rst during RUN slice 2 -> the next cycle shows IDLE, resp_valid=0, busy=0. A subsequent request 0x00FF+0x0001 -> 0x0100, cout 0.
- NIBBLE_ADD_OVF_EN:
  - 0x7FFF+0x0001 -> sum 0x8000, ovf 1, cout 0.
  - 0x8000+0x8000 -> sum 0x0000, ovf 1, cout 1.
  - 0x0001+0xFFFF -> ovf 0.
